// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - producer/consumer bundle for the instruction queue
interface instruction_queue_if #(
  parameter int IW    = 8,
  parameter int MW    = 2,
  parameter int AW    = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = IW - MW - AW;

  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [MW-1:0] mnm;
  logic [AW-1:0] wr_addr_mnm;
  logic [RW-1:0] rd_addr_wr_data;
  logic          ack;
  logic [CW-1:0] count;
  logic          ovf;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, mnm, wr_addr_mnm, rd_addr_wr_data, ack, count, ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, mnm, wr_addr_mnm, rd_addr_wr_data, ack, count, ovf
  );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - circular-buffer instruction queue with decoded head fields
module instruction_queue #(
  parameter int IW    = 8,
  parameter int MW    = 2,
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  instruction_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = IW - MW - AW;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          ack_q;
  logic          ovf_q;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // in_ready looks only at occupancy, so a full queue never accepts even if a pop is pending
  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready && !bus.flush;
  assign head      = out_valid ? mem[rd_ptr] : '0;

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.mnm             = head[IW-1 -: MW];
  assign bus.wr_addr_mnm     = head[IW-MW-1 -: AW];
  assign bus.rd_addr_wr_data = head[RW-1:0];
  assign bus.ack             = ack_q;
  assign bus.count           = count_q;
  assign bus.ovf             = ovf_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ack_q <= push;
      if (bus.in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard bench for instruction_queue
module tb_instruction_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] sb[$];
  logic [7:0] exp_w;
  logic [7:0] got_w;

  instruction_queue_if #(.IW(8), .MW(2), .AW(2), .DEPTH(4)) bus ();

  instruction_queue #(.IW(8), .MW(2), .AW(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 ||
        bus.ack !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b count=%0d in_ready=%b ack=%b ovf=%b, required 0 0 1 0 0",
               bus.out_valid, bus.count, bus.in_ready, bus.ack, bus.ovf);
    end
    checks++;
    got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
    if (got_w !== 8'h00) begin
      errors++;
      $display("FAIL reset_fields: got %h required 00", got_w);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; sb.push_back(8'hA5);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mnm !== 2'b10 || bus.wr_addr_mnm !== 2'b10 || bus.rd_addr_wr_data !== 4'h5 ||
        bus.out_valid !== 1'b1 || bus.count !== 3'd1 || bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL single_push: mnm=%b wr=%b rd=%h ov=%b count=%0d ack=%b, required 10 10 5 1 1 1",
               bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data, bus.out_valid, bus.count, bus.ack);
    end
    tick();
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_one_cycle: got %b required 0", bus.ack);
    end
    bus.out_ready = 1'b1;
    exp_w = sb.pop_front();
    got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL single_pop_head: got %h required %h", got_w, exp_w);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop_empty: count=%0d out_valid=%b required 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_fill_ovf();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = words[i]; sb.push_back(words[i]);
      tick();
      checks++;
      if (bus.ack !== 1'b1) begin
        errors++;
        $display("FAIL fill_ack[%0d]: got %b required 1", i, bus.ack);
      end
    end
    checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d in_ready=%b ovf=%b required 4 0 0", bus.count, bus.in_ready, bus.ovf);
    end
    bus.in_data = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.ovf !== 1'b1 || bus.count !== 3'd4 || bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d ack=%b required 1 4 0", bus.ovf, bus.count, bus.ack);
    end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
      got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
      checks++;
      if (bus.out_valid !== 1'b1 || got_w !== exp_w) begin
        errors++;
        $display("FAIL drain_head[%0d]: out_valid=%b got %h required 1 %h", i, bus.out_valid, got_w, exp_w);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || got_w !== 8'h00 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: count=%0d out_valid=%b fields=%h ovf=%b required 0 0 00 1",
               bus.count, bus.out_valid, got_w, bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h60 + 8'(i); sb.push_back(8'h60 + 8'(i));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      bus.in_data = 8'h70 + 8'(i * 9);
      exp_w = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
      sb.push_back(8'h70 + 8'(i * 9));
      got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL b2b_head[%0d]: got %h required %h", i, got_w, exp_w);
      end
      tick();
      checks++;
      if (bus.count !== 3'd2 || bus.ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b_count[%0d]: count=%0d ack=%b required 2 1", i, bus.count, bus.ack);
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_w = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
      got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL b2b_tail[%0d]: got %h required %h", i, got_w, exp_w);
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h90 + 8'(i); sb.push_back(8'h90 + 8'(i));
      tick();
    end
    checks++;
    if (bus.count !== 3'd3 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: count=%0d ovf=%b required 3 1", bus.count, bus.ovf);
    end
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    sb.delete();
    checks++;
    if (bus.count !== 3'd0 || bus.ovf !== 1'b0 || bus.ack !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d ovf=%b ack=%b out_valid=%b in_ready=%b required 0 0 0 0 1",
               bus.count, bus.ovf, bus.ack, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_when_empty: count=%0d out_valid=%b required 0 0", bus.count, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hE0 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || got_w !== 8'h00 ||
        bus.ack !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: count=%0d out_valid=%b fields=%h ack=%b in_ready=%b required 0 0 00 0 1",
               bus.count, bus.out_valid, got_w, bus.ack, bus.in_ready);
    end
    #3;
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b1; bus.in_data = 8'hC3; sb.push_back(8'hC3);
    tick();
    bus.in_valid = 1'b0;
    exp_w = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    got_w = {bus.mnm, bus.wr_addr_mnm, bus.rd_addr_wr_data};
    checks++;
    if (got_w !== exp_w || bus.mnm !== 2'b11 || bus.rd_addr_wr_data !== 4'h3 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_push: got %h count=%0d required %h 1", got_w, bus.count, exp_w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_fill_ovf();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
